// File: rtl/booth_radix4_seq.sv
// Sequential radix-4 Booth multiplier: one recoded digit per clock, ready/valid on both sides.
// Optional macro BOOTH_UNSIGNED_SEL_EN adds input tc (1 = signed, 0 = unsigned operands).
module booth_radix4_seq #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
`ifdef BOOTH_UNSIGNED_SEL_EN
    input  logic                 tc,
`endif
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     M,
    input  logic [WIDTH-1:0]     Q,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   Product,
    output logic                 busy
);
    localparam int N  = WIDTH / 2;
    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(N + 2);

    generate
        if (WIDTH < 4 || (WIDTH % 2) != 0) begin : g_bad_width
            $error("booth_radix4_seq: WIDTH must be even and >= 4");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t            state_reg;
    logic [PW-1:0]     acc_reg;
    logic [PW-1:0]     m_reg;
    logic [WIDTH+2:0]  q_reg;
    logic [CW-1:0]     cnt_reg;
    logic              signed_reg;

    logic              signed_in;
    logic [PW-1:0]     m_ext;
    logic [WIDTH+2:0]  q_ext;
    logic [PW-1:0]     digit_mult;
    logic [CW-1:0]     last_cnt;

`ifdef BOOTH_UNSIGNED_SEL_EN
    assign signed_in = tc;
`else
    assign signed_in = 1'b1;
`endif

    // q_ext[0] is the implicit bit -1; two extension bits on top feed the extra
    // unsigned digit (they duplicate the sign bit in signed mode and go unused).
    assign m_ext    = {{WIDTH{signed_in & M[WIDTH-1]}}, M};
    assign q_ext    = {{2{signed_in & Q[WIDTH-1]}}, Q, 1'b0};
    assign last_cnt = signed_reg ? CW'(N - 1) : CW'(N);

    // m_reg already carries the 2i shift, so the digit multiple is added directly.
    always_comb begin
        digit_mult = '0;
        case (q_reg[2:0])
            3'b001, 3'b010: digit_mult = m_reg;
            3'b011:         digit_mult = m_reg << 1;
            3'b100:         digit_mult = -(m_reg << 1);
            3'b101, 3'b110: digit_mult = -m_reg;
            default:        digit_mult = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg  <= IDLE;
            acc_reg    <= '0;
            m_reg      <= '0;
            q_reg      <= '0;
            cnt_reg    <= '0;
            signed_reg <= 1'b1;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        m_reg      <= m_ext;
                        q_reg      <= q_ext;
                        acc_reg    <= '0;
                        cnt_reg    <= '0;
                        signed_reg <= signed_in;
                        state_reg  <= CALC;
                    end
                end
                CALC: begin
                    acc_reg <= acc_reg + digit_mult;
                    m_reg   <= m_reg << 2;
                    q_reg   <= q_reg >> 2;
                    cnt_reg <= cnt_reg + 1'b1;
                    if (cnt_reg == last_cnt) begin
                        state_reg <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_reg == IDLE);
    assign out_valid = (state_reg == DONE);
    assign busy      = (state_reg != IDLE);
    assign Product   = acc_reg;

endmodule

// File: doc/booth_radix4_seq.md
BOOTH_RADIX4_SEQ -- requirements
Module: booth_radix4_seq

Interface
REQ-001 Parameter WIDTH, default 8, operand width in bits; the module SHALL elaborate only for even WIDTH >= 4 and SHALL stop elaboration with an error otherwise.
REQ-002 Derived constant N = WIDTH/2, the Booth digit count, SHALL NOT be overridable.
REQ-003 Port: clk  input  1  the single clock; all state SHALL change on its rising edge.
REQ-004 Port: reset  input  1  reset, asynchronous assert, active-low; the block SHALL be in reset whenever reset = 0.
REQ-005 Port: in_valid  input  1  operand pair present.
REQ-006 Port: in_ready  output  1  block can accept operands.
REQ-007 Port: M  input  WIDTH  multiplicand.
REQ-008 Port: Q  input  WIDTH  multiplier.
REQ-009 Port: out_valid  output  1  Product holds a completed result.
REQ-010 Port: out_ready  input  1  consumer takes the result.
REQ-011 Port: Product  output  2*WIDTH  result, two's complement when signed.
REQ-012 Port: busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, CALC and DONE.
REQ-014 IDLE: in_ready = 1; when in_valid = 1 on an edge, the FSM SHALL register M and Q, clear the accumulator, set digit counter = 0, and enter CALC.
REQ-015 CALC: each cycle SHALL recode one radix-4 digit from multiplier bits {2i+1, 2i, 2i-1}, with bit -1 = 0 (000/111 -> 0, 001/010 -> +M, 011 -> +2M, 100 -> -2M, 101/110 -> -M).
REQ-016 CALC: the digit multiple SHALL be sign-extended to 2*WIDTH bits, shifted left by 2i, and added to the accumulator modulo 2^(2*WIDTH); the counter SHALL then increment.
REQ-017 After the last digit (i = N-1 when signed) the FSM SHALL enter DONE; out_valid SHALL first be high N cycles after the acceptance cycle, with the acceptance cycle counted as cycle 0.
REQ-018 DONE: out_valid = 1, in_ready = 0, and Product SHALL be the exact product and SHALL remain stable until out_ready = 1 on an edge, after which the FSM SHALL enter IDLE.
REQ-019 in_ready SHALL be 0 in CALC and DONE; in_valid, M and Q SHALL be ignored there, and no operand captured in CALC or DONE SHALL affect the result.
REQ-020 A new operand pair SHALL be accepted no earlier than the cycle after the DONE->IDLE transition.
REQ-021 Product SHALL reflect the accumulator in CALC (value undefined for checking) and SHALL hold the last result in IDLE.
REQ-022 Every input combination SHALL give an exact result without overflow, including M = Q = -2^(WIDTH-1).

Reset
REQ-023 On reset = 0 the block SHALL immediately, without waiting for clk, set state IDLE, in_ready = 1, out_valid = 0, busy = 0, Product = 0, accumulator = 0, counter = 0.
REQ-024 Reset asserted during CALC or DONE SHALL abort the operation; no out_valid SHALL follow for the aborted operation.
REQ-025 After reset = 1, the first rising edge SHALL be able to accept operands.

Configuration
REQ-026 Macro BOOTH_UNSIGNED_SEL_EN: when defined, the block SHALL add port tc, input, 1 bit, registered with the operands at acceptance.
REQ-027 With BOOTH_UNSIGNED_SEL_EN, tc = 1 SHALL give signed operation as in REQ-015..017.
REQ-028 With BOOTH_UNSIGNED_SEL_EN, tc = 0 SHALL treat M and Q as unsigned: M zero-extended, Q zero-extended by one recoding digit, N+1 CALC cycles, out_valid at cycle N+1.
REQ-029 Without BOOTH_UNSIGNED_SEL_EN, port tc SHALL NOT exist and all operation SHALL be signed.

Verification (WIDTH = 8)
REQ-030 M = 0x80, Q = 0x80 (signed) -> Product = 0x4000, with out_valid at cycle 4.
REQ-031 M = 0x7F, Q = 0x80 -> 0xC080; then M = 0xFF, Q = 0x01 -> 0xFFFF; then M = 0x00, Q = 0x5A -> 0x0000.
REQ-032 out_ready held 0 for 10 cycles in DONE while in_valid = 1 with new operands -> Product stable, in_ready = 0, no new operation starts; out_ready = 1 -> IDLE, next pair accepted one cycle later.
REQ-033 reset pulsed low mid-CALC (counter = 2) -> outputs at reset values immediately, no spurious out_valid; the next operation 3 x -5 -> 0xFFF1.
REQ-034 With BOOTH_UNSIGNED_SEL_EN: tc = 0, M = Q = 0xFF -> 0xFE01 at cycle 5; tc = 1, same operands -> 0x0001 at cycle 4.
REQ-035 Random signed 8-bit pairs (>= 10000) with random in_valid/out_ready gaps -> every result matches the reference product; no result is lost or duplicated.
